// File: rtl/hwpe_stream_burst_arbiter_if.sv
// HWPE stream handshake bundle: valid/ready with data and byte strobes.
// source drives valid/data/strb and samples ready; sink is the mirror.
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic [STRB_WIDTH-1:0] strb;

  modport source (
    output valid, data, strb,
    input  ready
  );

  modport sink (
    input  valid, data, strb,
    output ready
  );

  modport master (
    output valid, data, strb,
    input  ready
  );

  modport slave (
    input  valid, data, strb,
    output ready
  );
endinterface

// File: rtl/hwpe_stream_burst_arbiter.sv
// Burst-granular round-robin arbiter sharing one stream sink (pop_o) among
// push_i[] requesters; grant_o is the one-hot owner, busy_o marks GRANT.
module hwpe_stream_burst_arbiter #(
  parameter int unsigned NB_IN_STREAMS = 2,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned STRB_WIDTH    = DATA_WIDTH / 8,
  parameter int unsigned BURST_LEN     = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clear_i,
  input  logic                     enable_i,
  hwpe_stream_intf_stream.sink     push_i [NB_IN_STREAMS],
  hwpe_stream_intf_stream.source   pop_o,
  output logic [NB_IN_STREAMS-1:0] grant_o,
  output logic                     busy_o
);

  localparam int unsigned IW = $clog2(NB_IN_STREAMS);
  localparam int unsigned CW = $clog2(BURST_LEN + 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]    state;
  logic [IW-1:0] owner;
  logic [IW-1:0] ptr;
  logic [CW-1:0] cnt;

  logic [NB_IN_STREAMS-1:0] in_valid;
  logic [DATA_WIDTH-1:0]    in_data [NB_IN_STREAMS];
  logic [STRB_WIDTH-1:0]    in_strb [NB_IN_STREAMS];
  logic [NB_IN_STREAMS-1:0] out_ready;

  logic          flush;
  logic          active;
  logic          hs;
  logic          found;
  logic [IW-1:0] winner;
  logic [IW-1:0] cand;

  for (genvar k = 0; k < NB_IN_STREAMS; k++) begin : g_port
    assign in_valid[k]     = push_i[k].valid;
    assign in_data[k]      = push_i[k].data;
    assign in_strb[k]      = push_i[k].strb;
    assign push_i[k].ready = out_ready[k];
  end

  assign flush = rst_i | clear_i;

  // Outputs are blanked during a flush so no handshake can occur in the
  // reset cycle even when the FSM is still in GRANT.
  assign active = (state == GRANT) && !flush;
  assign hs     = active && in_valid[owner] && pop_o.ready;

  assign pop_o.valid = active ? in_valid[owner] : 1'b0;
  assign pop_o.data  = active ? in_data[owner]  : '0;
  assign pop_o.strb  = active ? in_strb[owner]  : '0;

  assign out_ready =
    active ? (NB_IN_STREAMS'(pop_o.ready) << owner) : '0;

  assign grant_o =
    (state == GRANT) ? (NB_IN_STREAMS'(1) << owner) : '0;
  assign busy_o  = (state == GRANT);

  // Scan ptr+1, ptr+2, ... so the last winner gets lowest priority.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int o = 1; o <= int'(NB_IN_STREAMS); o++) begin
      cand = IW'((int'(ptr) + o) % int'(NB_IN_STREAMS));
      if (!found && in_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (flush) begin
      state <= IDLE;
      owner <= '0;
      ptr   <= IW'(NB_IN_STREAMS - 1);
      cnt   <= '0;
    end else begin
      unique case (1'b1)
        (state == IDLE): begin
          if (enable_i && found) begin
            state <= GRANT;
            owner <= winner;
            ptr   <= winner;
            cnt   <= '0;
          end
        end
        (state == GRANT): begin
          if (!in_valid[owner] ||
              (hs && cnt == CW'(BURST_LEN - 1))) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (hs) begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
